// File: rtl/ct_f_spsram_arb_ctrl_if.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_arb_ctrl_if
// Requester-side bus of the single-port SRAM arbiter: two request ports plus
// the shared read-return path.
//
// Handshake: req_n is the valid and gnt_n is the ready of port n. An access
// transfers in the cycle where req_n && gnt_n are both 1. Until then the
// requester holds req_n, wr_n, addr_n and wdata_n stable. Dropping req_n
// before a grant withdraws the request with no side effect. A read granted
// in cycle N returns in cycle N+1 as a one-cycle rvld_n pulse with rdata.
//
// Signals
//   req_0/1, wr_0/1      requester -> ctrl  request, 1 = write / 0 = read
//   addr_0/1             requester -> ctrl  word address
//   wdata_0/1            requester -> ctrl  write data
//   gnt_0/1              ctrl -> requester  combinational grant
//   rvld_0/1             ctrl -> requester  read-return valid
//   rdata                ctrl -> requester  shared read data
// ---------------------------------------------------------------------------
interface ct_f_spsram_arb_ctrl_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 128
);
  logic                  req_0;
  logic                  req_1;
  logic                  wr_0;
  logic                  wr_1;
  logic [ADDR_WIDTH-1:0] addr_0;
  logic [ADDR_WIDTH-1:0] addr_1;
  logic [DATA_WIDTH-1:0] wdata_0;
  logic [DATA_WIDTH-1:0] wdata_1;
  logic                  gnt_0;
  logic                  gnt_1;
  logic                  rvld_0;
  logic                  rvld_1;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req_0, req_1, wr_0, wr_1, addr_0, addr_1, wdata_0, wdata_1,
    input  gnt_0, gnt_1, rvld_0, rvld_1, rdata
  );

  modport slave (
    input  req_0, req_1, wr_0, wr_1, addr_0, addr_1, wdata_0, wdata_1,
    output gnt_0, gnt_1, rvld_0, rvld_1, rdata
  );
endinterface

// File: rtl/ct_f_spsram_arb_ctrl.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_arb_ctrl
// Two-requester round-robin arbiter in front of one single-port SRAM.
// After reset it clears every SRAM word to zero (INIT), then serves one
// granted access per cycle (RUN).
//
// Ports
//   CLK, RST     clock; synchronous active-high reset
//   bus          requester bus (slave side), see ct_f_spsram_arb_ctrl_if
//   init_done    1 once the SRAM clear has completed
//   A, CEN, GWEN, WEN, D   SRAM address / controls (active-low) / write data
//   Q            SRAM read data, valid the cycle after a read access
//   fsm_state    debug view of the FSM state (0 = INIT, 1 = RUN)
// ---------------------------------------------------------------------------
module ct_f_spsram_arb_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 128
) (
  input  logic                    CLK,
  input  logic                    RST,
  ct_f_spsram_arb_ctrl_if.slave   bus,
  output logic                    init_done,
  output logic [ADDR_WIDTH-1:0]   A,
  output logic                    CEN,
  output logic                    GWEN,
  output logic [DATA_WIDTH-1:0]   WEN,
  output logic [DATA_WIDTH-1:0]   D,
  input  logic [DATA_WIDTH-1:0]   Q,
  output logic                    fsm_state
);

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  done_q;
  logic                  rr_q;      // 0: requester 0 wins a tie, 1: requester 1
  logic                  rvld0_q;
  logic                  rvld1_q;
  logic                  g0;
  logic                  g1;

  // Grants are combinational so the access happens in the request cycle.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!RST && state == S_RUN) begin
      g0 = bus.req_0 & (~bus.req_1 | ~rr_q);
      g1 = bus.req_1 & (~bus.req_0 |  rr_q);
    end
  end

  // SRAM pins. The RST gate keeps the macro idle even before the first
  // reset edge has put the FSM into a known state.
  always_comb begin
    CEN  = 1'b1;
    GWEN = 1'b1;
    WEN  = '1;
    A    = init_cnt;
    D    = '0;
    if (!RST) begin
      if (state == S_INIT) begin
        CEN  = 1'b0;
        GWEN = 1'b0;
        WEN  = '0;
      end else if (g0) begin
        CEN = 1'b0;
        A   = bus.addr_0;
        if (bus.wr_0) begin
          GWEN = 1'b0;
          WEN  = '0;
          D    = bus.wdata_0;
        end
      end else if (g1) begin
        CEN = 1'b0;
        A   = bus.addr_1;
        if (bus.wr_1) begin
          GWEN = 1'b0;
          WEN  = '0;
          D    = bus.wdata_1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_INIT;
      init_cnt <= '0;
      done_q   <= 1'b0;
      rr_q     <= 1'b0;
      rvld0_q  <= 1'b0;
      rvld1_q  <= 1'b0;
    end else begin
      // g0/g1 are forced low in INIT, so no read return can start there.
      rvld0_q <= g0 & ~bus.wr_0;
      rvld1_q <= g1 & ~bus.wr_1;
      case (state)
        S_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_ADDR) begin
            state  <= S_RUN;
            done_q <= 1'b1;
          end
        end
        S_RUN: begin
          // Any grant hands priority to the other requester.
          if (g0) begin
            rr_q <= 1'b1;
          end else if (g1) begin
            rr_q <= 1'b0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // A reset arriving one cycle after a read grant must suppress its return,
  // hence the combinational RST gate on the registered flags.
  assign bus.gnt_0  = g0;
  assign bus.gnt_1  = g1;
  assign bus.rvld_0 = rvld0_q & ~RST;
  assign bus.rvld_1 = rvld1_q & ~RST;
  assign bus.rdata  = Q;
  assign init_done  = done_q & ~RST;
  assign fsm_state  = (state == S_RUN);

endmodule

// File: tb/tb_ct_f_spsram_arb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ct_f_spsram_arb_ctrl
// Bench for the SRAM arbiter: behavioural SRAM model, driver tasks with an
// independent arbitration/memory model, expected-read queue, final report.
// ---------------------------------------------------------------------------
module tb_ct_f_spsram_arb_ctrl;

  localparam int AW          = 14;
  localparam int DW          = 128;
  localparam int DEPTH       = 1 << AW;
  localparam int INIT_CYCLES = DEPTH;

  // ---------------- clock / reset ----------------
  logic clk;
  logic RST;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  ct_f_spsram_arb_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic          init_done;
  logic [AW-1:0] A;
  logic          CEN;
  logic          GWEN;
  logic [DW-1:0] WEN;
  logic [DW-1:0] D;
  logic [DW-1:0] Q;
  logic          fsm_state;

  ct_f_spsram_arb_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK       (clk),
    .RST       (RST),
    .bus       (bus),
    .init_done (init_done),
    .A         (A),
    .CEN       (CEN),
    .GWEN      (GWEN),
    .WEN       (WEN),
    .D         (D),
    .Q         (Q),
    .fsm_state (fsm_state)
  );

  // ---------------- SRAM model ----------------
  logic [DW-1:0] mem [0:DEPTH-1];
  int            wr_cnt [0:DEPTH-1];
  int            init_nz;
  logic          track;

  initial init_nz = 0;

  always @(posedge clk) begin
    if (CEN === 1'b0) begin
      if (GWEN === 1'b0) begin
        mem[A] <= (mem[A] & WEN) | (D & ~WEN);
        if (track) begin
          wr_cnt[A] <= wr_cnt[A] + 1;
          if (D !== '0 || WEN !== '0) init_nz <= init_nz + 1;
        end
      end else begin
        Q <= mem[A];
      end
    end
  end

  // ---------------- scoreboard state ----------------
  logic [DW:0]   exp_q[$];          // {port, data}
  logic [DW-1:0] ref_mem [int];
  logic          tb_rr;
  int            tb_cyc;
  int            gnt_err;
  logic          obs_g0;
  logic          obs_g1;
  int            n_checks;
  int            n_pass;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  // ---------------- driver tasks ----------------
  // One cycle: check the read return due now, apply new requests, compare
  // grants against the model and queue expected reads.
  task automatic step(input logic r0, input logic w0, input logic [AW-1:0] a0,
                      input logic [DW-1:0] d0, input logic r1, input logic w1,
                      input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic        eg0;
    logic        eg1;
    logic [DW:0] e;
    @(negedge clk);
    tb_cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rvld_port", {bus.rvld_1, bus.rvld_0}, e[DW] ? 2'b10 : 2'b01);
      check("rdata", bus.rdata, e[DW-1:0]);
    end else if (bus.rvld_0 || bus.rvld_1) begin
      check("rvld_spurious", {bus.rvld_1, bus.rvld_0}, '0);
    end
    bus.req_0 = r0; bus.wr_0 = w0; bus.addr_0 = a0; bus.wdata_0 = d0;
    bus.req_1 = r1; bus.wr_1 = w1; bus.addr_1 = a1; bus.wdata_1 = d1;
    eg0 = (tb_cyc >= INIT_CYCLES) && r0 && (!r1 || !tb_rr);
    eg1 = (tb_cyc >= INIT_CYCLES) && r1 && (!r0 ||  tb_rr);
    #1;
    obs_g0 = bus.gnt_0;
    obs_g1 = bus.gnt_1;
    if (obs_g0 !== eg0 || obs_g1 !== eg1) gnt_err++;
    if (eg0) begin
      tb_rr = 1'b1;
      if (w0) ref_mem[int'(a0)] = d0;
      else    exp_q.push_back({1'b0, ref_rd(a0)});
    end else if (eg1) begin
      tb_rr = 1'b0;
      if (w1) ref_mem[int'(a1)] = d1;
      else    exp_q.push_back({1'b1, ref_rd(a1)});
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic assert_rst();
    @(negedge clk);
    RST = 1'b1;
    exp_q.delete();
    #1;
    check("rst_rvld", {bus.rvld_1, bus.rvld_0}, '0);
    check("rst_gnt", {bus.gnt_1, bus.gnt_0}, '0);
    check("rst_cen", CEN, 1'b1);
    check("rst_gwen", GWEN, 1'b1);
    check("rst_wen", WEN, {DW{1'b1}});
    check("rst_init_done", init_done, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic release_rst();
    @(negedge clk);
    RST    = 1'b0;
    tb_cyc = 0;
    tb_rr  = 1'b0;
    track  = 1'b1;
    ref_mem.delete();
    exp_q.delete();
    #1;
    check("init_first_a", A, '0);
    check("init_first_cen", CEN, 1'b0);
    check("init_first_gwen", GWEN, 1'b0);
    check("init_first_wen", WEN, '0);
  endtask

  // Walk the whole clear sequence; optionally keep a read of 0x1234 pending
  // on port 0 so its grant lands exactly on the first RUN cycle.
  task automatic run_init(input logic hold_req0, input int round);
    int bad;
    for (int i = 1; i <= INIT_CYCLES; i++) begin
      step(hold_req0, 1'b0, 14'h1234, '0, 1'b0, 1'b0, '0, '0);
      if (i == INIT_CYCLES - 1) begin
        check("init_done_early", init_done, 1'b0);
        if (hold_req0) check("gnt0_in_init", obs_g0, 1'b0);
      end
      if (i == INIT_CYCLES) begin
        track = 1'b0;
        check("init_done", init_done, 1'b1);
        check("fsm_run", fsm_state, 1'b1);
        if (hold_req0) check("gnt0_first_run", obs_g0, 1'b1);
      end
    end
    bad = 0;
    for (int a = 0; a < DEPTH; a++) if (wr_cnt[a] != round) bad++;
    check("init_write_count", bad, 0);
    check("init_write_zero", init_nz, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] pat;
    logic [DW-1:0] rd;
    logic [7:0]    g0_seq;
    n_checks = 0; n_pass = 0; gnt_err = 0;
    tb_cyc = 0; tb_rr = 1'b0; track = 1'b0;
    RST = 1'b1;
    bus.req_0 = 1'b1; bus.wr_0 = 1'b0; bus.addr_0 = '0; bus.wdata_0 = '0;
    bus.req_1 = 1'b1; bus.wr_1 = 1'b0; bus.addr_1 = '0; bus.wdata_1 = '0;

    assert_rst();
    bus.req_0 = 1'b0;
    bus.req_1 = 1'b0;

    // Clear sequence with no traffic
    release_rst();
    run_init(1'b0, 1);
    idle();
    check("run_idle_cen", CEN, 1'b1);
    check("run_idle_gwen", GWEN, 1'b1);
    check("run_idle_wen", WEN, {DW{1'b1}});

    // Write 0x1234 from port 0, read it back from port 1
    pat = {16{8'hA5}};
    step(1'b1, 1'b1, 14'h1234, pat, 1'b0, 1'b0, '0, '0);
    check("wr_gnt0", obs_g0, 1'b1);
    check("wr_cen", CEN, 1'b0);
    check("wr_gwen", GWEN, 1'b0);
    check("wr_wen", WEN, '0);
    check("wr_a", A, 14'h1234);
    check("wr_d", D, pat);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 14'h1234, '0);
    check("rd_gnt1", obs_g1, 1'b1);
    check("rd_gwen", GWEN, 1'b1);
    check("rd_wen", WEN, {DW{1'b1}});
    check("rd_a", A, 14'h1234);

    // Never-written top address reads back as cleared
    step(1'b1, 1'b0, 14'h3FFF, '0, 1'b0, 1'b0, '0, '0);
    idle();

    // Read directly after a write to the same address
    rd = {$urandom(), $urandom(), $urandom(), $urandom()};
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 14'h0005, rd);
    step(1'b1, 1'b0, 14'h0005, '0, 1'b0, 1'b0, '0, '0);
    idle();

    // Preload 0..7 from port 0, then both ports read continuously
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b1, AW'(i), {$urandom(), $urandom(), $urandom(), $urandom()},
           1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(i + 8), '0);
      g0_seq[i] = obs_g0;
    end
    // Last grant went to port 0, so port 1 opens the alternation
    check("rr_alternation", g0_seq, 8'hAA);
    idle();

    // Random mixed traffic over a small address window
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
           {$urandom(), $urandom(), $urandom(), $urandom()},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
           {$urandom(), $urandom(), $urandom(), $urandom()});
    idle();
    idle();
    check("gnt_model_run", gnt_err, 0);

    // Reset right after a read grant: return suppressed, clear restarts at 0
    step(1'b1, 1'b0, 14'h0003, '0, 1'b0, 1'b0, '0, '0);
    check("pre_rst_gnt0", obs_g0, 1'b1);
    assert_rst();
    release_rst();
    // 0x1234 held A5.. before the reset; it must come back cleared
    run_init(1'b1, 2);
    idle();
    idle();

    check("gnt_model_final", gnt_err, 0);
    check("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
